serial_add_sub: RTL
===================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial WIDTH-bit adder/subtractor with a start/done handshake.
//  Performs A+B+cin or A-B-bin one bit per clock, LSB first, using a single carry/borrow flop.
//  Used where a parallel 4-bit adder costs too much area and a multi-cycle result is acceptable.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      synchronous active-low reset
//  start  in   1      request; sampled only when busy=0
//  op     in   1      0 = add, 1 = subtract; sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  cin    in   1      carry-in (add) / borrow-in (sub); sampled with start
//  s      out  WIDTH  result; valid when done=1, held until next accepted start
//  cout   out  1      carry-out (add) / borrow-out (sub), same validity as s
//  busy   out  1      1 while operation in progress
//  done   out  1      1-cycle pulse: s/cout valid
//  ovf    out  1      signed overflow (only with SERIAL_ADD_SUB_OVF_EN)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; s=0, cout=0, busy=0, done=0, ovf=0; internal regs cleared.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 -> load A,B shift regs, op, carry flop, count=0; go RUN.
//   RUN: each edge processes bit[count]; after WIDTH bits -> DONE.
//   DONE: done=1 for exactly one cycle; then IDLE. start=1 in DONE is accepted as in IDLE (back-to-back).
//  Accept rule: start honoured only when busy=0; start while busy=1 ignored, no side effects.
//  Latency: start sampled at edge k -> busy=1 after edge k; bits processed at edges k+1..k+WIDTH;
//   done=1, busy=0 after edge k+WIDTH. Throughput: one op per WIDTH+1 cycles.
//  Arithmetic per bit i:
//   add: s_i = a_i ^ b_i ^ c;  c' = maj(a_i, b_i, c); initial c = cin.
//   sub: computed as A + ~B + ~bin: s_i = a_i ^ ~b_i ^ c; c' = maj(a_i, ~b_i, c); initial c = ~cin.
//   Final: add -> cout = c; sub -> cout = ~c (borrow: 1 when A < B + bin, unsigned).
//  s shifts in MSB-first into an internal shift reg; visible s updated only on entering DONE
//   (s never shows partial results); s/cout hold through IDLE until next completion.
//  Wrap-around: results are modulo 2^WIDTH; overflow reported only via cout (and ovf if enabled).
//  Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//  Operand inputs may change freely while busy; only start-cycle values are used.
// CONFIGURATION
//  SERIAL_ADD_SUB_OVF_EN defined: ovf = carry into MSB ^ carry out of MSB (two's complement
//   overflow of the effective addition), updated with s on entering DONE, held like s, reset 0.
//  Undefined: no ovf logic or register; ovf port tied 0.
// TESTING (WIDTH=4)
//  add a=0101 b=0011 cin=0 -> s=1000 cout=0; busy 4 cycles, done 1 cycle after edge k+4.
//  add a=1111 b=0001 cin=0 -> s=0000 cout=1; add a=1111 b=1111 cin=1 -> s=1111 cout=1.
//  sub a=0011 b=0101 bin=0 -> s=1110 cout=1; sub a=0111 b=0111 bin=1 -> s=1111 cout=1; sub 1000-0001 -> 0111 cout=0.
//  start pulsed during busy with other operands -> ignored, first result unchanged; start in DONE -> next op busy immediately.
//  rst_n=0 at 2nd RUN cycle -> s=0, cout=0, busy=0, no done; fresh start afterwards computes correctly.
//  OVF_EN: add 0111+0001 -> s=1000 ovf=1; sub 1000-0001 -> ovf=1; add 0011+0001 -> ovf=0; without macro ovf=0 always.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/done handshake, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] s_sr;
    logic [CW-1:0]    cnt;
    logic             op_r, c;
    logic             accept, last;
    logic             b_eff, sum, c_nxt;
    logic [WIDTH-1:0] s_nxt;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));

    // Subtraction runs as A + ~B + ~bin, so only B is inverted per bit.
    assign b_eff = op_r ? ~b_sr[0] : b_sr[0];
    assign sum   = a_sr[0] ^ b_eff ^ c;
    assign c_nxt = (a_sr[0] & b_eff) | (a_sr[0] & c) | (b_eff & c);
    assign s_nxt = {sum, s_sr};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = RUN;
            RUN:     if (last) nxt = DONE;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            cnt  <= '0;
            op_r <= 1'b0;
            c    <= 1'b0;
            s    <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            op_r <= op;
            c    <= op ? ~cin : cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_nxt[WIDTH-1:1];
            c    <= c_nxt;
            cnt  <= cnt + CW'(1);
            if (last) begin
                s    <= s_nxt;
                cout <= op_r ? ~c_nxt : c_nxt;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic ovf_r;

    // On the last bit, c is the carry into the MSB and c_nxt the carry out.
    always_ff @(posedge clk) begin
        if (!rst_n)                    ovf_r <= 1'b0;
        else if (state == RUN && last) ovf_r <= c ^ c_nxt;
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule
